pca_reconstruct: RTL and testbench
==================================

Name: pca_reconstruct

Overview:
- Inverse of the PCA projection stage. Takes MIN_PC_NUM principal-component scores and rebuilds the PC_NUM-dimensional vector: recon[j] = sum over i of score[i]*basis[i][j].
- Uses the same basis matrix the projection consumes.
- Synthesizable signed fixed-point, one MAC per cycle. Streams one reconstructed element per handshake to the downstream reconstruction-error / IDS scoring logic.

Parameters:
- FP_SIZE, 64, width of every data word (signed two's complement fixed-point).
- FRAC_BITS, 32, number of fractional bits in every data word (scores, basis, output).
- PC_NUM, 32, length of the reconstructed vector (number of output elements).
- MIN_PC_NUM, 5, number of retained components (number of input scores).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  score vector valid.
- in_ready  out  1  block can accept a new score vector.
- score_vector  in  FP_SIZE x [0:MIN_PC_NUM-1]  signed scores; sampled on acceptance.
- basis  in  FP_SIZE x [0:MIN_PC_NUM-1][0:PC_NUM-1]  signed basis matrix; must stay stable from acceptance until the out_last handshake.
- out_valid  out  1  out_data holds a valid reconstructed element.
- out_ready  in  1  downstream accepts the element.
- out_data  out  FP_SIZE  reconstructed element j.
- out_index  out  $clog2(PC_NUM)  element index j.
- out_last  out  1  high with out_valid when j == PC_NUM-1.
- busy  out  1  a frame is in progress.
- sat_flag  out  1  sticky per frame: an element was clamped (macro-dependent).

Behaviour:
- Reset (async, reset_n low): state IDLE. in_ready=1 once released. out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, sat_flag=0. Accumulator and counters cleared. Reset mid-frame abandons the frame; no partial output is emitted afterwards.
- States:
  - IDLE: in_ready=1, busy=0.
  - MAC: in_ready=0, busy=1.
  - OUT: in_ready=0, busy=1, out_valid=1.
- IDLE -> MAC on the edge where in_valid&&in_ready (edge E0).
  - At E0: latch score_vector, j=0, i=0, acc=0, sat_flag=0.
  - in_valid while busy is ignored.
- MAC: on edges E1..E_M (M=MIN_PC_NUM), acc += score[i]*basis[i][j], i++.
  - Product width is 2*FP_SIZE. Accumulator width is 2*FP_SIZE+$clog2(MIN_PC_NUM)+1. There is no intermediate rounding.
  - On edge E_M, register out_data = (final sum) >>> FRAC_BITS (arithmetic shift, i.e. floor toward negative infinity), narrowed to FP_SIZE. Drive out_index=j and out_last=(j==PC_NUM-1), and go to OUT.
- OUT: hold out_data, out_index and out_last stable while out_ready=0, for any number of stall cycles.
  - On out_valid&&out_ready with j<PC_NUM-1: clear acc, i=0, j++, go to MAC.
  - On out_valid&&out_ready with j==PC_NUM-1: go to IDLE and drop out_valid. in_ready is high in the following cycle.
- Latency and throughput with out_ready held high:
  - First out_valid is visible in the cycle after E_M.
  - Element period is M+1 cycles.
  - The last handshake is at edge E_{PC_NUM*(M+1)}.
- Narrowing without the macro: keep the low FP_SIZE bits (wrap).
- Degenerate values: basis or scores all zero give out_data=0. MIN_PC_NUM=1 gives a period of 2 cycles.

Optional Feature:
- Macro PCA_RECON_SAT_EN.
- Defined: if the shifted sum exceeds the signed FP_SIZE range, out_data is clamped to 2^(FP_SIZE-1)-1 or -2^(FP_SIZE-1). sat_flag is set and stays set until the next acceptance or reset.
- Undefined: wrap narrowing applies and sat_flag is tied to 0.

Test Plan:
All scenarios use FP_SIZE=32, FRAC_BITS=16, PC_NUM=4, MIN_PC_NUM=2, so 1.0 = 0x00010000.
1. Identity rows: basis[0]={1.0,0,0,0}, basis[1]={0,1.0,0,0}, scores {2.0,-3.0}, out_ready=1 -> out_data 0x00020000, 0xFFFD0000, 0, 0 on indices 0..3. First out_valid visible 2 cycles after the accept edge. out_last only on index 3. in_ready high 12 cycles after the accept edge.
2. Backpressure: same frame, out_ready low for 5 cycles at index 1 -> out_data=0xFFFD0000 and out_index=1 held stable. No MAC advance, busy=1, in_ready=0. The frame resumes correctly.
3. Floor rounding: scores {0x00000001, 0}, basis[0][0]=0xFFFF8000 (-0.5) -> out_data[0]=0xFFFFFFFF.
4. Overflow: scores {0x7FFF0000, 0x7FFF0000}, all basis words 0x7FFF0000 -> with PCA_RECON_SAT_EN, out_data=0x7FFFFFFF and sat_flag=1. Without the macro, out_data=0x00020000 and sat_flag=0.
5. Reset mid-frame: pull reset_n low after the index-1 handshake -> all outputs go to reset values immediately with no further out_valid. After release, a new frame with scenario-1 data reproduces the scenario-1 outputs.
6. Busy-time input: hold in_valid high for the whole of frame 1 with a different score vector -> that vector is not accepted until in_ready returns. Frame 2 is then accepted on the first in_ready cycle and computed from the new scores.

Source files
------------

// File: rtl/pca_reconstruct.sv
// -----------------------------------------------------------------------------
// pca_reconstruct
//
// Rebuilds a PC_NUM-element vector from MIN_PC_NUM principal-component scores:
//   recon[j] = sum_i score[i] * basis[i][j]
// in signed fixed point (FRAC_BITS fractional bits everywhere), using a single
// multiply-accumulate per cycle. Each finished element is streamed out on a
// valid/ready handshake, one element per handshake, index 0 first.
//
// Per element: MIN_PC_NUM MAC cycles, then one or more OUT cycles. With
// out_ready held high an element is produced every MIN_PC_NUM+1 cycles.
//
// Optional build macro:
//   PCA_RECON_SAT_EN  - clamp elements that overflow the FP_SIZE signed range
//                       and report it on sat_flag (sticky for the frame).
//                       Undefined: the low FP_SIZE bits are kept (wrap) and
//                       sat_flag is tied low.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   in_valid      score vector offered
//   in_ready      block idle, can take a score vector
//   score_vector  MIN_PC_NUM signed scores, sampled on acceptance
//   basis         MIN_PC_NUM x PC_NUM signed basis; held stable for the frame
//   out_valid     out_data/out_index/out_last are valid
//   out_ready     downstream takes the element
//   out_data      reconstructed element j
//   out_index     element index j
//   out_last      high with out_valid on element PC_NUM-1
//   busy          a frame is in progress
//   sat_flag      an element of this frame was clamped
//
// PC_NUM must be at least 2.
// -----------------------------------------------------------------------------
module pca_reconstruct #(
    parameter int FP_SIZE    = 64,
    parameter int FRAC_BITS  = 32,
    parameter int PC_NUM     = 32,
    parameter int MIN_PC_NUM = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [FP_SIZE-1:0]   score_vector [0:MIN_PC_NUM-1],
    input  logic signed [FP_SIZE-1:0]   basis        [0:MIN_PC_NUM-1][0:PC_NUM-1],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FP_SIZE-1:0]          out_data,
    output logic [$clog2(PC_NUM)-1:0]   out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic                        sat_flag
);

    localparam int PROD_W = 2 * FP_SIZE;
    localparam int ACC_W  = 2 * FP_SIZE + $clog2(MIN_PC_NUM) + 1;
    localparam int IW     = (MIN_PC_NUM > 1) ? $clog2(MIN_PC_NUM) : 1;
    localparam int JW     = $clog2(PC_NUM);

    localparam logic [IW-1:0] I_LAST = IW'(MIN_PC_NUM - 1);
    localparam logic [JW-1:0] J_LAST = JW'(PC_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [FP_SIZE-1:0] score_q [0:MIN_PC_NUM-1];
    logic signed [ACC_W-1:0]   acc_q;
    logic [IW-1:0]             i_q;
    logic [JW-1:0]             j_q;
    logic [FP_SIZE-1:0]        data_q;

    logic                      accept;
    logic                      handshake;
    logic                      mac_last;

    logic signed [FP_SIZE-1:0] sel_score;
    logic signed [FP_SIZE-1:0] sel_basis;
    logic signed [PROD_W-1:0]  a_ext;
    logic signed [PROD_W-1:0]  b_ext;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic [FP_SIZE-1:0]        narrowed;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge values; blocking = here would create ordering races.
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (i_q == I_LAST) state_d = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = (j_q == J_LAST) ? S_IDLE : S_MAC;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign handshake = (state_q == S_OUT) && out_ready;
    assign mac_last  = (state_q == S_MAC) && (i_q == I_LAST);

    // ------------------------------------------------------------------
    // MAC datapath: full-precision product, no rounding until the end.
    // ------------------------------------------------------------------
    always_comb begin
        sel_score = score_q[i_q];
        sel_basis = basis[i_q][j_q];
        // Sign-extend both operands so the product is exact in PROD_W bits.
        a_ext     = {{FP_SIZE{sel_score[FP_SIZE-1]}}, sel_score};
        b_ext     = {{FP_SIZE{sel_basis[FP_SIZE-1]}}, sel_basis};
        prod      = a_ext * b_ext;
        sum       = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        // Arithmetic shift: floor toward negative infinity.
        shifted   = sum >>> FRAC_BITS;
    end

`ifdef PCA_RECON_SAT_EN
    logic overflow;
    logic sat_q;

    // In range only if every bit from the FP_SIZE sign bit upward agrees.
    assign overflow = !((&shifted[ACC_W-1:FP_SIZE-1]) || !(|shifted[ACC_W-1:FP_SIZE-1]));

    always_comb begin
        narrowed = shifted[FP_SIZE-1:0];
        if (overflow) begin
            narrowed = shifted[ACC_W-1] ? {1'b1, {(FP_SIZE-1){1'b0}}}
                                        : {1'b0, {(FP_SIZE-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= 1'b0;
        end else if (mac_last && overflow) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_shift_bits;

    // Wrap narrowing: the bits above FP_SIZE are simply discarded.
    assign narrowed          = shifted[FP_SIZE-1:0];
    assign unused_shift_bits = ^shifted[ACC_W-1:FP_SIZE];
    assign sat_flag          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Score latch
    // ------------------------------------------------------------------
    // NOTE: the score registers have no reset; they are always loaded on
    // acceptance before anything reads them, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (accept) score_q <= score_vector;
    end

    // ------------------------------------------------------------------
    // Accumulator, counters and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        acc_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= sum;
                    if (i_q == I_LAST) begin
                        data_q <= narrowed;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (handshake) begin
                        acc_q <= '0;
                        i_q   <= '0;
                        // Return j to 0 after the last element so the idle
                        // block presents index 0.
                        j_q   <= (j_q == J_LAST) ? '0 : j_q + 1'b1;
                    end
                end
                default: begin
                    acc_q <= '0;
                    i_q   <= '0;
                    j_q   <= '0;
                end
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_index = j_q;
    assign out_last  = out_valid && (j_q == J_LAST);

endmodule

// File: tb/tb_pca_reconstruct.sv
// -----------------------------------------------------------------------------
// tb_pca_reconstruct
//
// Directed bench for pca_reconstruct with FP_SIZE=32, FRAC_BITS=16, PC_NUM=4,
// MIN_PC_NUM=2 (1.0 = 0x00010000, element period 3 cycles). Expected values
// are hand-computed constants. Build with +define+PCA_RECON_SAT_EN to check
// the clamping variant of the overflow frame.
// -----------------------------------------------------------------------------
module tb_pca_reconstruct;

    localparam int FP  = 32;
    localparam int FB  = 16;
    localparam int PC  = 4;
    localparam int MPC = 2;

    logic                clk;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [FP-1:0] score_vector [0:MPC-1];
    logic signed [FP-1:0] basis        [0:MPC-1][0:PC-1];
    logic                out_valid;
    logic                out_ready;
    logic [FP-1:0]       out_data;
    logic [1:0]          out_index;
    logic                out_last;
    logic                busy;
    logic                sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    logic [FP-1:0] exp_id [0:PC-1];

    pca_reconstruct #(
        .FP_SIZE   (FP),
        .FRAC_BITS (FB),
        .PC_NUM    (PC),
        .MIN_PC_NUM(MPC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .score_vector(score_vector),
        .basis       (basis),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step at least once, then until out_valid, bounded.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        step();
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, " valid"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            step();
            n++;
        end
        check({tag, " idle"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < MPC; i++) begin
            score_vector[i] = '0;
            for (int j = 0; j < PC; j++) basis[i][j] = '0;
        end
    endtask

    task automatic load_identity();
        clear_inputs();
        basis[0][0]     = 32'h0001_0000;
        basis[1][1]     = 32'h0001_0000;
        score_vector[0] = 32'h0002_0000;
        score_vector[1] = 32'hFFFD_0000;
    endtask

    // Accept the identity frame and check it cycle by cycle with out_ready high.
    task automatic identity_frame(input string tag);
        int idx;
        load_identity();
        out_ready = 1'b1;
        check({tag, " in_ready pre"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, " busy E0"}, {63'd0, busy}, 64'd1);
        check({tag, " in_ready E0"}, {63'd0, in_ready}, 64'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k % 3 == 2) begin
                idx = (k - 2) / 3;
                check($sformatf("%s valid k%0d", tag, k), {63'd0, out_valid}, 64'd1);
                check($sformatf("%s data k%0d", tag, k), {32'd0, out_data}, {32'd0, exp_id[idx]});
                check($sformatf("%s index k%0d", tag, k), {62'd0, out_index}, 64'(idx));
                check($sformatf("%s last k%0d", tag, k), {63'd0, out_last}, 64'(idx == PC - 1));
            end else begin
                check($sformatf("%s novalid k%0d", tag, k), {63'd0, out_valid}, 64'd0);
            end
        end
        check({tag, " in_ready end"}, {63'd0, in_ready}, 64'd1);
        check({tag, " busy end"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [FP-1:0] exp_ovf;
        logic          exp_sat;
`ifdef PCA_RECON_SAT_EN
        exp_ovf = 32'h7FFF_FFFF;
        exp_sat = 1'b1;
`else
        exp_ovf = 32'h0002_0000;
        exp_sat = 1'b0;
`endif
        exp_id[0] = 32'h0002_0000;
        exp_id[1] = 32'hFFFD_0000;
        exp_id[2] = 32'h0000_0000;
        exp_id[3] = 32'h0000_0000;

        // ---------------- reset state ----------------
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_inputs();
        step();
        step();
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst out_data", {32'd0, out_data}, 64'd0);
        check("rst out_index", {62'd0, out_index}, 64'd0);
        check("rst out_last", {63'd0, out_last}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst sat", {63'd0, sat_flag}, 64'd0);
        reset_n = 1'b1;
        step();
        check("rst in_ready", {63'd0, in_ready}, 64'd1);

        // ---------------- 1: identity rows, exact timing ----------------
        identity_frame("s1");

        // ---------------- 2: backpressure on index 1 ----------------
        load_identity();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid("s2 e0");
        check("s2 data0", {32'd0, out_data}, {32'd0, exp_id[0]});
        wait_valid("s2 e1");
        out_ready = 1'b0;
        check("s2 data1", {32'd0, out_data}, {32'd0, exp_id[1]});
        for (int s = 0; s < 5; s++) begin
            step();
            check($sformatf("s2 stall%0d valid", s), {63'd0, out_valid}, 64'd1);
            check($sformatf("s2 stall%0d data", s), {32'd0, out_data}, 64'hFFFD_0000);
            check($sformatf("s2 stall%0d index", s), {62'd0, out_index}, 64'd1);
            check($sformatf("s2 stall%0d busy", s), {63'd0, busy}, 64'd1);
            check($sformatf("s2 stall%0d in_ready", s), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        wait_valid("s2 e2");
        check("s2 index2", {62'd0, out_index}, 64'd2);
        check("s2 data2", {32'd0, out_data}, 64'd0);
        wait_valid("s2 e3");
        check("s2 index3", {62'd0, out_index}, 64'd3);
        check("s2 last3", {63'd0, out_last}, 64'd1);
        step();
        wait_idle("s2");

        // ---------------- 3: floor rounding ----------------
        clear_inputs();
        score_vector[0] = 32'h0000_0001;
        basis[0][0]     = 32'hFFFF_8000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid("s3 e0");
        check("s3 floor", {32'd0, out_data}, 64'hFFFF_FFFF);
        wait_valid("s3 e1");
        check("s3 data1", {32'd0, out_data}, 64'd0);
        step();
        wait_idle("s3");

        // ---------------- 4: overflow ----------------
        for (int i = 0; i < MPC; i++) begin
            score_vector[i] = 32'h7FFF_0000;
            for (int j = 0; j < PC; j++) basis[i][j] = 32'h7FFF_0000;
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("s4 sat cleared", {63'd0, sat_flag}, 64'd0);
        wait_valid("s4 e0");
        check("s4 data0", {32'd0, out_data}, {32'd0, exp_ovf});
        check("s4 sat0", {63'd0, sat_flag}, {63'd0, exp_sat});
        wait_valid("s4 e1");
        wait_valid("s4 e2");
        wait_valid("s4 e3");
        check("s4 data3", {32'd0, out_data}, {32'd0, exp_ovf});
        step();
        wait_idle("s4");
        check("s4 sat sticky", {63'd0, sat_flag}, {63'd0, exp_sat});

        // ---------------- 5: reset mid-frame ----------------
        load_identity();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("s5 sat clr on accept", {63'd0, sat_flag}, 64'd0);
        wait_valid("s5 e0");
        wait_valid("s5 e1");
        step();
        reset_n = 1'b0;
        #1;
        check("s5 rst valid", {63'd0, out_valid}, 64'd0);
        check("s5 rst data", {32'd0, out_data}, 64'd0);
        check("s5 rst index", {62'd0, out_index}, 64'd0);
        check("s5 rst busy", {63'd0, busy}, 64'd0);
        check("s5 rst sat", {63'd0, sat_flag}, 64'd0);
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("s5 hold%0d valid", s), {63'd0, out_valid}, 64'd0);
        end
        reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            check($sformatf("s5 post%0d valid", s), {63'd0, out_valid}, 64'd0);
        end
        identity_frame("s5");

        // ---------------- 6: in_valid held while busy ----------------
        load_identity();
        in_valid = 1'b1;
        step();
        // New vector stays offered for the whole first frame.
        score_vector[0] = 32'h0001_0000;
        score_vector[1] = 32'h0000_8000;
        for (int e = 0; e < PC; e++) begin
            wait_valid($sformatf("s6a e%0d", e));
            check($sformatf("s6a data%0d", e), {32'd0, out_data}, {32'd0, exp_id[e]});
            check($sformatf("s6a in_ready%0d", e), {63'd0, in_ready}, 64'd0);
        end
        step();
        check("s6 in_ready gap", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        check("s6 busy frame2", {63'd0, busy}, 64'd1);
        wait_valid("s6b e0");
        check("s6b data0", {32'd0, out_data}, 64'h0001_0000);
        wait_valid("s6b e1");
        check("s6b data1", {32'd0, out_data}, 64'h0000_8000);
        wait_valid("s6b e2");
        check("s6b data2", {32'd0, out_data}, 64'd0);
        wait_valid("s6b e3");
        check("s6b last", {63'd0, out_last}, 64'd1);
        step();
        wait_idle("s6b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
